// File: rtl/fabric_pkg.sv
// Shared definitions for the fabric chain: per-stage mode encodings and the
// width of one stage's mode field inside the configuration shift register.
package fabric_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_BYPASS = 2'b00,
    MODE_MAC    = 2'b01,
    MODE_SWAP   = 2'b10,
    MODE_ZERO   = 2'b11
  } mode_e;

endpackage

// File: rtl/fabric_chain_stage.sv
// One stage of the fabric chain: a mac_cluster, the mode mux selecting what
// the stage forwards, and the pipeline register (lanes + valid) that all
// stages advance in lockstep.
module fabric_chain_stage
  import fabric_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic [MODE_W-1:0] mode,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b
);

  logic [DATA_W-1:0] mac0_s;
  logic [DATA_W-1:0] mac1_s;
  logic [DATA_W-1:0] nxt_a_s;
  logic [DATA_W-1:0] nxt_b_s;
  logic              valid_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;

  // Lane A feeds both multiplier inputs of slot 0, lane B those of slot 1.
  mac_cluster #(.DATA_W(DATA_W)) u_mac (
    .a0   (in_a),
    .b0   (in_a),
    .a1   (in_b),
    .b1   (in_b),
    .out0 (mac0_s),
    .out1 (mac1_s)
  );

  // Select the lane values this stage forwards according to its mode.
  always_comb begin
    nxt_a_s = in_a;
    nxt_b_s = in_b;
    case (mode_e'(mode))
      MODE_BYPASS: begin
        nxt_a_s = in_a;
        nxt_b_s = in_b;
      end
      MODE_MAC: begin
        nxt_a_s = mac0_s;
        nxt_b_s = mac1_s;
      end
      MODE_SWAP: begin
        nxt_a_s = in_b;
        nxt_b_s = in_a;
      end
      MODE_ZERO: begin
        nxt_a_s = {DATA_W{1'b0}};
        nxt_b_s = {DATA_W{1'b0}};
      end
      default: begin
        nxt_a_s = in_a;
        nxt_b_s = in_b;
      end
    endcase
  end

  // Pipeline register: captures on a chain-wide advance, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      a_r     <= {DATA_W{1'b0}};
      b_r     <= {DATA_W{1'b0}};
    end else if (advance) begin
      valid_r <= in_valid;
      a_r     <= nxt_a_s;
      b_r     <= nxt_b_s;
    end
  end

  assign out_valid = valid_r;
  assign out_a     = a_r;
  assign out_b     = b_r;

endmodule

// File: rtl/mac_cluster.sv
// Behavioural stand-in for the mac_cluster macro so the chain elaborates on
// its own. Only the port shape matters to the chain; the arithmetic here is a
// simple per-lane product truncated to the lane width.
module mac_cluster #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1
);

  assign out0 = a0 * b0;
  assign out1 = a1 * b1;

endmodule

// File: rtl/fabric_chain.sv
// fabric_chain: NUM_CLUSTERS mode-configurable stages in a fixed-latency
// pipeline with valid/ready handshakes and a serial configuration port.
// New modes are staged in a shift register and committed only once the pipe
// has drained, so data in flight always completes under the old modes.
// Optional feature: define FABRIC_CHAIN_CFG_READBACK_EN to drive config_out
// from the top of the shift register for daisy-chaining; otherwise it is 0.
module fabric_chain
  import fabric_pkg::*;
#(
  parameter int NUM_CLUSTERS = 8,
  parameter int DATA_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_en,
  input  logic                config_in,
  output logic                config_out,
  output logic                cfg_done,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_data
);

  localparam int CFG_W = MODE_W * NUM_CLUSTERS;

  logic                  advance_s;
  logic                  xfer_s;
  logic                  busy_s;
  logic                  cfg_fall_s;
  logic                  commit_s;
  logic [NUM_CLUSTERS:0] valid_s;
  logic [DATA_W-1:0]     lane_a_s [NUM_CLUSTERS+1];
  logic [DATA_W-1:0]     lane_b_s [NUM_CLUSTERS+1];
  logic [CFG_W-1:0]      shift_r;
  logic [CFG_W-1:0]      modes_r;
  logic                  cfg_en_d_r;
  logic                  commit_pending_r;
  logic                  cfg_done_r;

  // Index 0 of the lane/valid arrays is the chain input; index k+1 is stage k.
  assign advance_s   = !valid_s[NUM_CLUSTERS] | out_ready;
  assign in_ready    = advance_s & !cfg_en & !commit_pending_r;
  assign xfer_s      = in_valid & in_ready;
  assign valid_s[0]  = xfer_s;
  assign lane_a_s[0] = in_data[DATA_W-1:0];
  assign lane_b_s[0] = in_data[2*DATA_W-1:DATA_W];
  assign busy_s      = |valid_s[NUM_CLUSTERS:1];
  assign cfg_fall_s  = cfg_en_d_r & !cfg_en;
  assign commit_s    = commit_pending_r & !cfg_en & !busy_s;

  for (genvar k = 0; k < NUM_CLUSTERS; k++) begin : g_stage
    fabric_chain_stage #(.DATA_W(DATA_W)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance   (advance_s),
      .mode      (modes_r[MODE_W*k +: MODE_W]),
      .in_valid  (valid_s[k]),
      .in_a      (lane_a_s[k]),
      .in_b      (lane_b_s[k]),
      .out_valid (valid_s[k+1]),
      .out_a     (lane_a_s[k+1]),
      .out_b     (lane_b_s[k+1])
    );
  end

  assign out_valid = valid_s[NUM_CLUSTERS];
  assign out_data  = {lane_a_s[NUM_CLUSTERS], lane_b_s[NUM_CLUSTERS]};
  assign cfg_done  = cfg_done_r;

  // Configuration: serial shift, commit scheduling and the active mode copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r          <= {CFG_W{1'b0}};
      modes_r          <= {CFG_W{1'b0}};
      cfg_en_d_r       <= 1'b0;
      commit_pending_r <= 1'b0;
      cfg_done_r       <= 1'b0;
    end else begin
      cfg_en_d_r <= cfg_en;
      cfg_done_r <= commit_s;
      if (cfg_en) begin
        shift_r <= {shift_r[CFG_W-2:0], config_in};
      end
      // A re-asserted cfg_en cancels any commit still waiting for the drain.
      if (cfg_en) begin
        commit_pending_r <= 1'b0;
      end else if (cfg_fall_s) begin
        commit_pending_r <= 1'b1;
      end else if (commit_s) begin
        commit_pending_r <= 1'b0;
      end
      if (commit_s) begin
        modes_r <= shift_r;
      end
    end
  end

`ifdef FABRIC_CHAIN_CFG_READBACK_EN
  assign config_out = shift_r[CFG_W-1];
`else
  assign config_out = 1'b0;
`endif

endmodule

// File: tb/tb_fabric_chain.sv
// Directed self-checking bench for fabric_chain (8 stages, 8-bit lanes).
module tb_fabric_chain;

  logic        clk;
  logic        rst_n;
  logic        cfg_en;
  logic        config_in;
  logic        config_out;
  logic        cfg_done;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int total;
  int bad;

  fabric_chain #(.NUM_CLUSTERS(8), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_en     (cfg_en),
    .config_in  (config_in),
    .config_out (config_out),
    .cfg_done   (cfg_done),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_word(input logic [15:0] w);
    cfg_en = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      config_in = w[i];
      tick();
    end
    cfg_en    = 1'b0;
    config_in = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int found;
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      tick();
      if (cfg_done) found = 1;
    end
    chk(tag, found, 1);
    tick();
    chk({tag, "_pulse_end"}, cfg_done, 1'b0);
  endtask

  task automatic send_one(input string tag, input logic [15:0] w, input logic [15:0] exp);
    int found;
    in_valid = 1'b1;
    in_data  = w;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      if (out_valid) begin
        found = 1;
        chk({tag, "_data"}, out_data, exp);
      end else begin
        tick();
      end
    end
    chk({tag, "_seen"}, found, 1);
    tick();
  endtask

  initial begin
    logic [15:0] wq [3];
    logic [31:0] seq;
    logic        exp_bit;
    int          sent;
    int          got;
    int          dn;
    int          seen;

    total = 0;
    bad = 0;
    rst_n = 1'b0;
    cfg_en = 1'b0;
    config_in = 1'b0;
    in_valid = 1'b0;
    in_data = 16'h0000;
    out_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_cfg_done", cfg_done, 1'b0);
    chk("rst_config_out", config_out, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", in_ready, 1'b1);

    // Default bypass: A=34 ends up in the upper half, 8 cycles of latency
    in_valid = 1'b1;
    in_data  = 16'h1234;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    chk("byp_not_yet", out_valid, 1'b0);
    tick();
    chk("byp_valid", out_valid, 1'b1);
    chk("byp_data", out_data, 16'h3412);
    tick();
    chk("byp_drained", out_valid, 1'b0);

    // Stage 0 = SWAP, others bypass: output equals input word as-is
    shift_word(16'h0002);
    tick();
    chk("cfg_pending_in_ready", in_ready, 1'b0);
    chk("cfg_done_not_early", cfg_done, 1'b0);
    wait_done("cfg_swap_done");
    send_one("swap", 16'h0201, 16'h0201);

    // Backpressure: 10 words, out_ready low for cycles 9..13
    sent = 0;
    got = 0;
    for (int c = 0; c < 60 && got < 10; c++) begin
      out_ready = !(c >= 9 && c < 14);
      in_valid  = (sent < 10);
      in_data   = 16'hA000 + 16'(sent);
      #1;
      if (!out_ready) chk("stall_in_ready", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        chk("bp_data", out_data, 16'hA000 + 16'(got));
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", got, 10);
    chk("bp_no_extra", out_valid, 1'b0);

    // Commit while busy: 3 words held in the pipe, new config = stage 3 ZERO
    wq[0] = 16'h0A0B;
    wq[1] = 16'h1C1D;
    wq[2] = 16'h2E2F;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = wq[i];
      tick();
    end
    in_valid = 1'b0;
    shift_word(16'h00C0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("busy_no_done", cfg_done, 1'b0);
      chk("busy_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    got = 0;
    dn = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) begin
        if (got < 3) chk("busy_data", out_data, wq[got]);
        else chk("busy_extra", out_valid, 1'b0);
        got++;
      end
      if (cfg_done) begin
        dn++;
        chk("done_after_drain", got, 3);
      end else if (dn == 0) begin
        chk("drain_in_ready", in_ready, 1'b0);
      end
      tick();
    end
    chk("busy_got", got, 3);
    chk("busy_done_once", dn, 1);

    // Stage 3 ZERO: any input yields zero
    send_one("zero_a", 16'hBEEF, 16'h0000);
    send_one("zero_b", 16'h1234, 16'h0000);

    // Readback: config_out follows config_in 16 cycles later
    seq = {16'hC3A5, 16'h0002};
    cfg_en = 1'b1;
    for (int j = 0; j < 32; j++) begin
      config_in = seq[31-j];
      tick();
      if (j >= 15) begin
`ifdef FABRIC_CHAIN_CFG_READBACK_EN
        exp_bit = seq[31-(j-15)];
`else
        exp_bit = 1'b0;
`endif
        chk("readback", config_out, exp_bit);
      end
    end
    cfg_en = 1'b0;
    config_in = 1'b0;
    wait_done("cfg_swap2_done");
    send_one("swap2", 16'h0102, 16'h0102);

    // Async reset mid-stream
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h5500 + 16'(i);
      tick();
    end
    chk("pre_rst_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, 16'h0000);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("post_rst_silent", seen, 0);
    send_one("post_rst_bypass", 16'h1234, 16'h3412);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fabric_chain.md
FABRIC_CHAIN -- requirements
Module: fabric_chain

Interface
REQ-001 SHALL have parameter NUM_CLUSTERS, default 8, meaning the number of chained mac_cluster stages (legal values 1..32).
REQ-002 SHALL have parameter DATA_W, default 8, meaning the width of each of the two data lanes A and B.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port cfg_en, input, 1 bit: serial configuration shift enable.
REQ-006 SHALL have port config_in, input, 1 bit: serial configuration data.
REQ-007 SHALL have port config_out, output, 1 bit: serial configuration readback (see REQ-025).
REQ-008 SHALL have port cfg_done, output, 1 bit: one-cycle pulse when a new configuration becomes active.
REQ-009 SHALL have port in_valid, input, 1 bit, and in_ready, output, 1 bit: input handshake.
REQ-010 SHALL have port in_data, input, 2*DATA_W bits: A in [DATA_W-1:0], B in [2*DATA_W-1:DATA_W].
REQ-011 SHALL have port out_valid, output, 1 bit, and out_ready, input, 1 bit: output handshake.
REQ-012 SHALL have port out_data, output, 2*DATA_W bits: {A_last, B_last}, A in the upper half.

Function
REQ-013 SHALL treat each stage as having a 2-bit mode: 00 bypass (A,B pass through), 01 mac (A drives A0/B0, B drives A1/B1, out0->A, out1->B), 10 swap (A<->B), 11 zero (both lanes 0).
REQ-014 SHALL register each stage's lane outputs and a valid bit, giving a fixed latency of NUM_CLUSTERS cycles from an accepted input to out_valid, regardless of mode.
REQ-015 SHALL advance all stages together when advance = !out_valid | out_ready; otherwise all stage registers hold.
REQ-016 SHALL drive in_ready = advance & !cfg_en & !commit_pending; a transfer occurs when in_valid & in_ready.
REQ-017 SHALL insert a bubble (valid 0) into stage 0 on an advance cycle with no input transfer.
REQ-018 SHALL hold a shift register of 2*NUM_CLUSTERS bits: while cfg_en=1, shift one bit per cycle, config_in entering bit 0; bits [2k+1:2k] form stage k's mode.
REQ-019 SHALL set commit_pending on the cycle after cfg_en falls (1 then 0).
REQ-020 SHALL copy the shift register to the active mode register while commit_pending=1 and no stage holds a valid entry, then clear commit_pending and pulse cfg_done for exactly one cycle.
REQ-021 SHALL leave the active modes unchanged while shifting, so in-flight data completes under the old configuration.
REQ-022 SHALL discard a cfg_en pulse that is reasserted before commit; the commit then waits for the next falling edge of cfg_en.

Reset
REQ-023 SHALL, while rst_n=0, clear all stage valid bits and data, the shift register, the active modes (all stages bypass), and commit_pending; out_valid=0, out_data=0, cfg_done=0, config_out=0.
REQ-024 SHALL, on reset mid-operation, drop in-flight data and partial configuration without emitting any output.

Configuration
REQ-025 SHALL, with FABRIC_CHAIN_CFG_READBACK_EN defined, drive config_out with bit 2*NUM_CLUSTERS-1 of the shift register, so that multiple instances can be daisy-chained; without the macro, config_out SHALL be constant 0 and no readback logic SHALL exist.

Structure
REQ-026 SHALL place the mode encodings (BYPASS, MAC, SWAP, ZERO) and the mode width constant in shared package fabric_pkg.
REQ-027 SHALL implement one stage (the mac_cluster instance, the mode mux and the pipeline register) as sub-module fabric_chain_stage, instantiated NUM_CLUSTERS times in a generate loop; mac_cluster remains a blackbox.

Verification
REQ-028 SHALL check reset defaults (all bypass): input 16'h12_34 accepted -> after 8 cycles out_data=16'h3412 (A=8'h34 in the upper half), out_valid=1.
REQ-029 SHALL check configuration: shift 16 bits with stage 0 = SWAP and the rest bypass, drop cfg_en -> cfg_done pulses once; input A=8'h01, B=8'h02 -> out_data=16'h0201.
REQ-030 SHALL check backpressure: stream 10 words with out_ready=0 from cycle 9 for 5 cycles -> no word is lost or duplicated, order is preserved, and in_ready=0 during the stall.
REQ-031 SHALL check a commit with the pipe busy: 3 valid words in flight and cfg_en dropped -> the words exit with the old modes, cfg_done fires only after the pipe is empty, and in_ready=0 until then.
REQ-032 SHALL check a stage in ZERO mode: any input -> out_data=16'h0000; and shifting with the macro defined -> config_out equals config_in delayed by 16 cycles.
REQ-033 SHALL check async reset asserted mid-stream: out_valid=0 immediately, and after release modes are bypass and nothing is emitted.
